// File: rtl/func_dispatcher.sv
// Operand FIFO and issue sequencer for the `func` core: buffers (a,b) pairs,
// starts one operation at a time, and returns each result with a sequence number.
module func_dispatcher #(
    parameter int DEPTH = 4,
    parameter int A_W   = 8,
    parameter int B_W   = 8,
    parameter int Y_W   = 5,
    parameter int SEQ_W = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic [A_W-1:0]             in_a_bi,
    input  logic [B_W-1:0]             in_b_bi,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [Y_W-1:0]             out_y_bo,
    output logic [SEQ_W-1:0]           out_seq_bo,
    output logic [A_W-1:0]             f_a_bo,
    output logic [B_W-1:0]             f_b_bo,
    output logic                       f_start_o,
    input  logic [1:0]                 f_busy_bi,
    input  logic [Y_W-1:0]             f_y_bi,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;

    logic [A_W+B_W-1:0]     r_mem [DEPTH];
    logic [PTR_W-1:0]       r_wr_ptr;
    logic [PTR_W-1:0]       r_rd_ptr;
    logic [CNT_W-1:0]       r_count;

    logic [A_W-1:0]         r_f_a;
    logic [B_W-1:0]         r_f_b;
    logic [Y_W-1:0]         r_out_y;
    logic                   r_out_valid;
    logic [SEQ_W-1:0]       r_seq;
    logic [1:0]             r_guard;

    logic                   w_push;
    logic                   w_pop;
    logic                   w_busy;
    logic                   w_guard_done;
    logic                   w_capture;
    logic                   w_out_hs;
    logic                   w_start;
    logic [A_W+B_W-1:0]     w_head;

    assign in_ready_o   = (r_count < CNT_W'(DEPTH));
    assign w_push       = in_valid_i & in_ready_o;
    assign w_busy       = |f_busy_bi;
    // Busy is re-checked in IDLE as well: after a local reset the core may still be running.
    assign w_pop        = (r_state == S_IDLE) && (r_count != '0) && !w_busy;
    assign w_guard_done = (r_guard == 2'd2);
    assign w_capture    = (r_state == S_WAIT) && w_guard_done && !w_busy;
    assign w_out_hs     = r_out_valid & out_ready_i;
    assign w_head       = r_mem[r_rd_ptr];

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_pop)     w_state_nxt = S_ISSUE;
            S_ISSUE:                w_state_nxt = S_WAIT;
            S_WAIT:  if (w_capture) w_state_nxt = S_DONE;
            S_DONE:  if (w_out_hs)  w_state_nxt = S_IDLE;
            default:                w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_start = 1'b0;
        if (r_state == S_ISSUE) begin
            w_start = 1'b1;
        end
    end

    // Storage array carries no reset; validity is tracked by the pointers and count.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {in_a_bi, in_b_bi};
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_f_a       <= '0;
            r_f_b       <= '0;
            r_out_y     <= '0;
            r_out_valid <= 1'b0;
            r_seq       <= '0;
            r_guard     <= '0;
        end else begin
            if (w_pop) begin
                r_f_a <= w_head[A_W+B_W-1:B_W];
                r_f_b <= w_head[B_W-1:0];
            end
            // The guard gives the core two cycles to raise busy before it is trusted.
            if (r_state == S_ISSUE) begin
                r_guard <= '0;
            end else if ((r_state == S_WAIT) && !w_guard_done) begin
                r_guard <= r_guard + 2'd1;
            end
            if (w_capture) begin
                r_out_y     <= f_y_bi;
                r_out_valid <= 1'b1;
            end else if (w_out_hs) begin
                r_out_valid <= 1'b0;
                r_seq       <= r_seq + SEQ_W'(1);
            end
        end
    end

    assign out_valid_o = r_out_valid;
    assign out_y_bo    = r_out_y;
    assign out_seq_bo  = r_seq;
    assign f_a_bo      = r_f_a;
    assign f_b_bo      = r_f_b;
    assign f_start_o   = w_start;
    assign count_o     = r_count;

endmodule

// File: tb/tb_func_dispatcher.sv
// Scoreboard bench for func_dispatcher with a behavioural `func` core of random latency.
module tb_func_dispatcher;

    logic       clk = 1'b0;
    logic       rst_i;
    logic       in_valid_i;
    logic       in_ready_o;
    logic [7:0] in_a_bi;
    logic [7:0] in_b_bi;
    logic       out_valid_o;
    logic       out_ready_i;
    logic [4:0] out_y_bo;
    logic [3:0] out_seq_bo;
    logic [7:0] f_a_bo;
    logic [7:0] f_b_bo;
    logic       f_start_o;
    logic [1:0] f_busy_bi;
    logic [4:0] f_y_bi;
    logic [2:0] count_o;

    func_dispatcher #(.DEPTH(4), .A_W(8), .B_W(8), .Y_W(5), .SEQ_W(4)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .in_a_bi(in_a_bi), .in_b_bi(in_b_bi),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .out_y_bo(out_y_bo), .out_seq_bo(out_seq_bo),
        .f_a_bo(f_a_bo), .f_b_bo(f_b_bo), .f_start_o(f_start_o),
        .f_busy_bi(f_busy_bi), .f_y_bi(f_y_bi), .count_o(count_o)
    );

    always #5 clk = ~clk;

    function automatic int ref_y(input int a, input int b);
        int c;
        int n;
        int s;
        c = 0;
        while ((c + 1) * (c + 1) * (c + 1) <= b) c++;
        n = a + c;
        s = 0;
        while ((s + 1) * (s + 1) <= n) s++;
        return s;
    endfunction

    // Core model: optional one-cycle delay before busy, busy for lat cycles, y garbage until done.
    int         m_pre = 0;
    int         m_cnt = 0;
    int         force_lat = 0;
    logic [4:0] m_y = 5'd0;
    logic [4:0] m_res = 5'd0;

    always @(posedge clk) begin
        if (f_start_o) begin
            m_pre <= int'($urandom_range(0, 1));
            m_cnt <= (force_lat != 0) ? force_lat : int'($urandom_range(1, 6));
            m_y   <= 5'd31;
            m_res <= 5'(ref_y(int'(f_a_bo), int'(f_b_bo)));
        end else if (m_pre > 0) begin
            m_pre <= m_pre - 1;
        end else if (m_cnt > 0) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1) m_y <= m_res;
        end
    end

    always_comb begin
        f_busy_bi = 2'b00;
        if (m_pre == 0 && m_cnt != 0) f_busy_bi = (m_cnt % 2 == 1) ? 2'b01 : 2'b10;
        f_y_bi = m_y;
    end

    typedef struct {
        int y;
        int seq;
    } exp_t;

    exp_t sb[$];
    int   exp_seq = 0;
    int   n_push = 0;
    int   n_start = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Evaluate the handshakes that the coming posedge will perform, then advance to the negedge.
    task automatic cycle();
        exp_t e;
        if (!rst_i) begin
            sb.delete();
            exp_seq = 0;
            n_push  = 0;
            n_start = 0;
        end else begin
            if (out_valid_o && out_ready_i) begin
                if (sb.size() == 0) begin
                    check_eq("sb_underflow", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check_eq("y", int'(out_y_bo), e.y);
                    check_eq("seq", int'(out_seq_bo), e.seq);
                end
            end
            if (in_valid_i && in_ready_o) begin
                e.y   = ref_y(int'(in_a_bi), int'(in_b_bi));
                e.seq = exp_seq;
                sb.push_back(e);
                exp_seq = (exp_seq + 1) % 16;
                n_push++;
            end
            if (f_start_o) begin
                n_start++;
                check_eq("start_while_busy", int'(f_busy_bi), 0);
            end
        end
        @(negedge clk);
    endtask

    task automatic push(input int a, input int b);
        bit ok;
        ok = 1'b0;
        in_a_bi    = 8'(a);
        in_b_bi    = 8'(b);
        in_valid_i = 1'b1;
        for (int i = 0; i < 300; i++) begin
            ok = in_ready_o;
            cycle();
            if (ok) break;
        end
        in_valid_i = 1'b0;
        if (!ok) check_eq("push_timeout", 0, 1);
    endtask

    task automatic do_reset(input int n);
        rst_i = 1'b0;
        for (int i = 0; i < n; i++) cycle();
        rst_i = 1'b1;
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (sb.size() == 0 && !out_valid_o && count_o == 0 && f_busy_bi == 0 && !f_start_o) begin
                done = 1'b1;
                break;
            end
            cycle();
        end
        check_eq("drain_done", int'(done), 1);
        check_eq("starts_per_push", n_start, n_push);
    endtask

    task automatic wait_valid(input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (out_valid_o) begin
                seen = 1'b1;
                break;
            end
            cycle();
        end
        check_eq(tag, int'(seen), 1);
    endtask

    int starts0;

    initial begin
        rst_i       = 1'b0;
        in_valid_i  = 1'b0;
        in_a_bi     = 8'd0;
        in_b_bi     = 8'd0;
        out_ready_i = 1'b0;

        // Reset state
        do_reset(3);
        check_eq("rst_count", int'(count_o), 0);
        check_eq("rst_in_ready", int'(in_ready_o), 1);
        check_eq("rst_out_valid", int'(out_valid_o), 0);
        check_eq("rst_out_y", int'(out_y_bo), 0);
        check_eq("rst_out_seq", int'(out_seq_bo), 0);
        check_eq("rst_f_a", int'(f_a_bo), 0);
        check_eq("rst_f_b", int'(f_b_bo), 0);
        check_eq("rst_f_start", int'(f_start_o), 0);
        check_eq("ref_12_60", ref_y(12, 60), 3);
        check_eq("ref_123_223", ref_y(123, 223), 11);

        // Back-to-back stream with a ready consumer
        out_ready_i = 1'b1;
        push(0, 0);
        push(1, 1);
        push(12, 60);
        push(123, 223);
        drain();

        // Backpressure until the FIFO fills
        do_reset(2);
        out_ready_i = 1'b0;
        push(255, 255);
        push(255, 30);
        push(30, 255);
        push(1, 255);
        push(255, 1);
        check_eq("full_count", int'(count_o), 4);
        check_eq("full_ready", int'(in_ready_o), 0);
        in_a_bi    = 8'd7;
        in_b_bi    = 8'd7;
        in_valid_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            check_eq("full_stall", int'(in_ready_o), 0);
            cycle();
        end
        in_valid_i = 1'b0;
        check_eq("full_count_hold", int'(count_o), 4);
        wait_valid("held_valid");
        starts0 = n_start;
        for (int i = 0; i < 5; i++) cycle();
        check_eq("held_y", int'(out_y_bo), 16);
        check_eq("held_seq", int'(out_seq_bo), 0);
        check_eq("held_no_start", n_start - starts0, 0);
        out_ready_i = 1'b1;
        drain();

        // Result and operands held while the consumer stalls
        out_ready_i = 1'b0;
        push(45, 64);
        wait_valid("stall_valid");
        for (int i = 0; i < 10; i++) begin
            check_eq("stall_valid_hold", int'(out_valid_o), 1);
            check_eq("stall_y", int'(out_y_bo), 7);
            check_eq("stall_f_a", int'(f_a_bo), 45);
            check_eq("stall_f_b", int'(f_b_bo), 64);
            cycle();
        end
        out_ready_i = 1'b1;
        drain();

        // Sequence number wrap
        do_reset(2);
        out_ready_i = 1'b1;
        for (int i = 0; i < 17; i++) push(1, 1);
        drain();
        check_eq("seq_after_wrap", int'(out_seq_bo), 1);

        // Local reset while the core is busy
        force_lat = 30;
        push(200, 200);
        for (int i = 0; i < 100; i++) begin
            if (f_busy_bi != 2'b00) break;
            cycle();
        end
        check_eq("core_busy_before_rst", int'(f_busy_bi != 2'b00), 1);
        push(9, 9);
        force_lat = 0;
        do_reset(1);
        check_eq("mid_rst_count", int'(count_o), 0);
        check_eq("mid_rst_valid", int'(out_valid_o), 0);
        check_eq("mid_rst_y", int'(out_y_bo), 0);
        check_eq("mid_rst_seq", int'(out_seq_bo), 0);
        check_eq("mid_rst_f_a", int'(f_a_bo), 0);
        check_eq("mid_rst_f_b", int'(f_b_bo), 0);
        check_eq("mid_rst_core_busy", int'(f_busy_bi != 2'b00), 1);
        push(45, 64);
        drain();

        // Simultaneous push and pop at occupancy 2
        out_ready_i = 1'b0;
        push(3, 8);
        push(100, 27);
        push(50, 125);
        wait_valid("pp_valid");
        check_eq("pp_count_before", int'(count_o), 2);
        out_ready_i = 1'b1;
        cycle();
        out_ready_i = 1'b0;
        in_a_bi     = 8'd80;
        in_b_bi     = 8'd216;
        in_valid_i  = 1'b1;
        check_eq("pp_ready", int'(in_ready_o), 1);
        check_eq("pp_count_mid", int'(count_o), 2);
        cycle();
        in_valid_i = 1'b0;
        check_eq("pp_count_after", int'(count_o), 2);
        out_ready_i = 1'b1;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
